// File: rtl/ctrl_pkg.sv
// Shared definitions for the mux-select sequencer.
//   state_e     : sequencer states
//   clog2_min1  : select width for an N-way mux, never narrower than 1 bit
//   MODO_ALL/ONE: values of the modo input
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic MODO_ALL = 1'b0;
  localparam logic MODO_ONE = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_idx_counter.sv
// Nested hold / constant / function index counter.
//   clr_i        : load h=0, c=0, f=start_f_i
//   adv_i        : step one cycle (h, then c on hold wrap, then f on c wrap)
//   end_f_i      : index of the last function of the sequence
//   c_o, f_o     : current constant / function index
//   last_hold_o  : final cycle of the hold window (accumulator write cycle)
//   last_const_o : write cycle of the last constant of a function
//   last_term_o  : write cycle of the last constant of the last function
module ctrl_idx_counter
  import ctrl_pkg::*;
#(
  parameter int N_CONST     = 5,
  parameter int N_FUN       = 3,
  parameter int HOLD_CYCLES = 1,
  parameter int CONST_W     = clog2_min1(N_CONST),
  parameter int FUN_W       = clog2_min1(N_FUN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [FUN_W-1:0]   start_f_i,
  input  logic [FUN_W-1:0]   end_f_i,
  output logic [CONST_W-1:0] c_o,
  output logic [FUN_W-1:0]   f_o,
  output logic               last_hold_o,
  output logic               last_const_o,
  output logic               last_term_o
);

  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);

  logic [HOLD_W-1:0]  h_q, h_d;
  logic [CONST_W-1:0] c_q, c_d;
  logic [FUN_W-1:0]   f_q, f_d;

  assign last_hold_o  = (h_q == HOLD_W'(HOLD_CYCLES - 1));
  assign last_const_o = last_hold_o && (c_q == CONST_W'(N_CONST - 1));
  assign last_term_o  = last_const_o && (f_q == end_f_i);
  assign c_o = c_q;
  assign f_o = f_q;

  always_comb begin
    h_d = h_q;
    c_d = c_q;
    f_d = f_q;
    if (clr_i) begin
      h_d = '0;
      c_d = '0;
      f_d = start_f_i;
    end else if (adv_i) begin
      if (!last_hold_o) begin
        h_d = h_q + HOLD_W'(1);
      end else begin
        h_d = '0;
        if (c_q == CONST_W'(N_CONST - 1)) begin
          c_d = '0;
          f_d = f_q + FUN_W'(1);
        end else begin
          c_d = c_q + CONST_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      c_q <= '0;
      f_q <= '0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
      f_q <= f_d;
    end
  end

endmodule

// File: rtl/control_mux_seq.sv
// Sequencer for the constant / function / accumulator muxes of the
// evaluation datapath. A start (bandera) walks N_CONST terms for all
// functions (modo=0) or for one captured function (modo=1), holding each
// term HOLD_CYCLES cycles.
//   bandera  : start request, looked at only in IDLE
//   modo     : 0 sweep all functions, 1 single function fun_in
//   fun_in   : function index for modo=1 (saturated to N_FUN-1)
//   sel_const/sel_fun : mux selects
//   sel_acum : 0 load term, 1 add term to feedback
//   acum_en  : accumulator write enable
//   fun_done : strobe, accumulator holds a finished function result
//   busy     : CLEAR..DONE
//   done     : end-of-sequence strobe
// Outputs are decoded purely from flops (state, counters, fun_done flag).
module control_mux_seq
  import ctrl_pkg::*;
#(
  parameter int N_CONST     = 5,
  parameter int N_FUN       = 3,
  parameter int HOLD_CYCLES = 1,
  localparam int CONST_W    = clog2_min1(N_CONST),
  localparam int FUN_W      = clog2_min1(N_FUN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bandera,
  input  logic               modo,
  input  logic [FUN_W-1:0]   fun_in,
  output logic [CONST_W-1:0] sel_const,
  output logic [FUN_W-1:0]   sel_fun,
  output logic               sel_acum,
  output logic               acum_en,
  output logic               fun_done,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [FUN_W-1:0]   end_f_q, end_f_d;
  logic               fun_done_q;
  logic [FUN_W-1:0]   start_f;
  logic               clr, adv;
  logic [CONST_W-1:0] c;
  logic [FUN_W-1:0]   f;
  logic               last_hold, last_const, last_term;

  // Start/end function indices are resolved from the inputs at the start
  // edge only; later changes of modo/fun_in cannot reach the counters.
  always_comb begin
    start_f = '0;
    if (modo == MODO_ONE)
      start_f = (int'(fun_in) >= N_FUN) ? FUN_W'(N_FUN - 1) : fun_in;
    end_f_d = (modo == MODO_ONE) ? start_f : FUN_W'(N_FUN - 1);
  end

  ctrl_idx_counter #(
    .N_CONST    (N_CONST),
    .N_FUN      (N_FUN),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CONST_W    (CONST_W),
    .FUN_W      (FUN_W)
  ) u_idx (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .adv_i       (adv),
    .start_f_i   (start_f),
    .end_f_i     (end_f_q),
    .c_o         (c),
    .f_o         (f),
    .last_hold_o (last_hold),
    .last_const_o(last_const),
    .last_term_o (last_term)
  );

  // Next state. The counters are frozen on the last term so DONE keeps
  // showing the final selects.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE:  if (bandera) begin
                 state_d = S_CLEAR;
                 clr     = 1'b1;
               end
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (last_term) state_d = S_DONE;
               else           adv     = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      end_f_q    <= '0;
      fun_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (clr) end_f_q <= end_f_d;
      fun_done_q <= (state_q == S_RUN) && last_const;
    end
  end

  // Moore output decode.
  always_comb begin
    sel_const = '0;
    sel_fun   = '0;
    sel_acum  = 1'b0;
    acum_en   = 1'b0;
    fun_done  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        sel_fun = f;
        busy    = 1'b1;
      end
      S_RUN: begin
        sel_const = c;
        sel_fun   = f;
        sel_acum  = (c != '0);
        acum_en   = last_hold;
        fun_done  = fun_done_q;
        busy      = 1'b1;
      end
      S_DONE: begin
        sel_const = c;
        sel_fun   = f;
        sel_acum  = (c != '0);
        fun_done  = fun_done_q;
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_mux_seq.sv
module tb_control_mux_seq;

  localparam int NC = 5;
  localparam int NF = 3;

  typedef struct packed {
    logic [2:0] sc;
    logic [1:0] sf;
    logic       sa;
    logic       ae;
    logic       fd;
    logic       busy;
    logic       done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: default DUT (HOLD=1), index 1: HOLD=3
  logic [1:0]      rst_v, band_v, modo_v;
  logic [1:0][1:0] fin_v;
  logic [1:0][2:0] sc;
  logic [1:0][1:0] sf;
  logic [1:0]      sa, ae, fd, bz, dn;

  vec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  control_mux_seq #(.N_CONST(NC), .N_FUN(NF), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .bandera(band_v[0]), .modo(modo_v[0]),
    .fun_in(fin_v[0]), .sel_const(sc[0]), .sel_fun(sf[0]), .sel_acum(sa[0]),
    .acum_en(ae[0]), .fun_done(fd[0]), .busy(bz[0]), .done(dn[0])
  );

  control_mux_seq #(.N_CONST(NC), .N_FUN(NF), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .bandera(band_v[1]), .modo(modo_v[1]),
    .fun_in(fin_v[1]), .sel_const(sc[1]), .sel_fun(sf[1]), .sel_acum(sa[1]),
    .acum_en(ae[1]), .fun_done(fd[1]), .busy(bz[1]), .done(dn[1])
  );

  function automatic vec_t obs(input int w);
    vec_t v;
    v.sc = sc[w]; v.sf = sf[w]; v.sa = sa[w]; v.ae = ae[w];
    v.fd = fd[w]; v.busy = bz[w]; v.done = dn[w];
    return v;
  endfunction

  // Reference sequence: CLEAR, every (f,c,h) RUN cycle, DONE.
  task automatic gen(input int hold, input bit md, input int fi);
    int   start, stop;
    bit   pend;
    vec_t v;
    start = md ? ((fi >= NF) ? NF - 1 : fi) : 0;
    stop  = md ? start : NF - 1;
    pend  = 1'b0;
    v = '0; v.sf = 2'(start); v.busy = 1'b1;
    q.push_back(v);
    for (int f = start; f <= stop; f++)
      for (int c = 0; c < NC; c++)
        for (int h = 0; h < hold; h++) begin
          v = '0;
          v.sc = 3'(c); v.sf = 2'(f); v.sa = (c != 0); v.ae = (h == hold - 1);
          v.fd = pend; v.busy = 1'b1;
          q.push_back(v);
          pend = (c == NC - 1) && (h == hold - 1);
        end
    v = '0;
    v.sc = 3'(NC - 1); v.sf = 2'(stop); v.sa = (NC > 1);
    v.fd = pend; v.busy = 1'b1; v.done = 1'b1;
    q.push_back(v);
  endtask

  task automatic push_idle();
    q.push_back('0);
  endtask

  // Pops one expected vector per cycle; bandera drops after vector drop_at.
  task automatic drive_check(input int w, input int drop_at, input string name, input bit scramble);
    int   idx;
    vec_t exp_v, got;
    idx = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      exp_v = q.pop_front();
      got   = obs(w);
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h (sc=%0d sf=%0d sa=%b ae=%b fd=%b busy=%b done=%b) required %h",
                 name, idx, got, got.sc, got.sf, got.sa, got.ae, got.fd, got.busy, got.done, exp_v);
      end
      if (idx == drop_at) begin
        band_v[w] = 1'b0;
        if (scramble) begin
          modo_v[w] = ~modo_v[w];
          fin_v[w]  = 2'($urandom_range(0, 3));
        end
      end
      idx++;
    end
  endtask

  task automatic kick(input int w, input bit md, input int fi);
    band_v[w] = 1'b1;
    modo_v[w] = md;
    fin_v[w]  = 2'(fi);
  endtask

  task automatic test_reset();
    vec_t got;
    rst_v = 2'b11; band_v = '0; modo_v = '0; fin_v = '0;
    #1;
    for (int w = 0; w < 2; w++) begin
      got = obs(w);
      vectors++;
      if (got !== vec_t'(0)) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got %h required 0", w, got);
      end
    end
    @(negedge clk);
    rst_v = 2'b00;
    push_idle();
    drive_check(0, -1, "reset_idle", 1'b0);
  endtask

  task automatic test_sweep();
    kick(0, 1'b0, 3);
    gen(1, 1'b0, 3); push_idle();
    drive_check(0, 0, "sweep", 1'b1);
  endtask

  task automatic test_single();
    kick(0, 1'b1, 2);
    gen(1, 1'b1, 2); push_idle();
    drive_check(0, 0, "single_f2", 1'b1);
  endtask

  task automatic test_hold3();
    kick(1, 1'b1, 0);
    gen(3, 1'b1, 0); push_idle();
    drive_check(1, 0, "hold3", 1'b1);
  endtask

  task automatic test_saturate();
    kick(0, 1'b1, 3);
    gen(1, 1'b1, 3); push_idle();
    drive_check(0, 0, "saturate", 1'b1);
  endtask

  // bandera stays high through the whole first run and the IDLE gap.
  task automatic test_back_to_back();
    kick(0, 1'b1, 1);
    gen(1, 1'b1, 1); push_idle();
    gen(1, 1'b1, 1); push_idle();
    drive_check(0, 2 + NC + 1, "back_to_back", 1'b0);
  endtask

  task automatic test_reset_mid();
    vec_t exp_v, got;
    kick(0, 1'b0, 0);
    gen(1, 1'b0, 0);
    // indices 0..9: CLEAR, then terms up to f=1,c=3
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_v = q.pop_front();
      got = obs(0);
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_pre[%0d]: got %h required %h", i, got, exp_v);
      end
      if (i == 0) band_v[0] = 1'b0;
    end
    q.delete();
    #1 rst_v[0] = 1'b1;
    #1;
    got = obs(0);
    vectors++;
    if (got !== vec_t'(0)) begin
      miscompares++;
      $display("FAIL reset_async: got %h required 0", got);
    end
    @(negedge clk);
    rst_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) push_idle();
    drive_check(0, -1, "reset_mid_idle", 1'b0);
    kick(0, 1'b1, 1);
    gen(1, 1'b1, 1); push_idle();
    drive_check(0, 0, "after_reset", 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_hold3();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_mux_seq.md
Name: control_mux_seq

Overview:
- Parametrised successor to the fixed 3/2/1-bit mux-select controller.
- Sequences the constant, function and accumulator multiplexers of the evaluation datapath.
- On a start flag (bandera), walks N_CONST constants for one or all N_FUN functions, holding each term HOLD_CYCLES cycles for datapath latency.
- Drives accumulator clear/enable, per-function result strobes and a done handshake.

Parameters:
- N_CONST, 5, number of constant terms per function (>=1)
- N_FUN, 3, number of functions (>=1)
- HOLD_CYCLES, 1, cycles each term is held before accumulation (>=1)
- CONST_W, max(1,clog2(N_CONST)), derived width of sel_const
- FUN_W, max(1,clog2(N_FUN)), derived width of sel_fun

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bandera  in  1  start request, sampled only in IDLE
- modo  in  1  0 = sweep all functions, 1 = single function fun_in
- fun_in  in  FUN_W  function index used when modo=1; captured at start
- sel_const  out  CONST_W  constant mux select
- sel_fun  out  FUN_W  function mux select
- sel_acum  out  1  0 = accumulator loads term, 1 = accumulator adds term to feedback
- acum_en  out  1  accumulator register write enable
- fun_done  out  1  one-cycle strobe: accumulator holds a finished function result
- busy  out  1  high from CLEAR through DONE inclusive
- done  out  1  one-cycle end-of-sequence strobe

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal counters 0. Reset mid-sequence aborts with no done and no fun_done.
- States: IDLE, CLEAR, RUN, DONE. Registered Moore outputs.
- IDLE: outputs 0. When bandera=1 at a clock edge: capture modo and fun_in; go to CLEAR. Function start index is fun_in if modo=1, else 0.
  - If fun_in >= N_FUN with modo=1: saturate to N_FUN-1.
- CLEAR (1 cycle): busy=1; sel_const=0; sel_fun=start index; sel_acum=0; acum_en=0. Go to RUN.
- RUN: one term per HOLD_CYCLES cycles.
  - Counters: hold count h (0..HOLD_CYCLES-1), then c (0..N_CONST-1), then f.
  - sel_const=c and sel_fun=f are stable for the whole hold window.
  - acum_en=1 only when h=HOLD_CYCLES-1.
  - sel_acum=0 while c=0, else 1. Each function restarts its accumulation.
  - fun_done=1 in the cycle after the write of term c=N_CONST-1 of each function. This is also the first cycle of the next function, or the DONE cycle.
  - Wrap: c wraps to 0 and f increments after c=N_CONST-1.
  - Exit to DONE after the last term of f=N_FUN-1 (modo=0), or of the single captured function (modo=1).
- DONE (1 cycle): done=1; busy=1; sel_* hold their last values; acum_en=0. Go to IDLE.
- Latency: let T = N_CONST*N_FUN (modo=0) or N_CONST (modo=1). With bandera seen at edge 0, done is high in cycle 2+T*HOLD_CYCLES.
- bandera while busy: ignored, not queued. bandera held high continuously: restart occurs in the cycle after DONE returns to IDLE (IDLE lasts at least 1 cycle).
- modo and fun_in changes while busy: no effect.
- N_CONST=1: sel_acum stays 0 throughout.
- N_FUN=1: sel_fun is constantly 0.

Decomposition:
- Shared package (ctrl_pkg):
  - state enum (IDLE, CLEAR, RUN, DONE)
  - clog2-with-min-1 width function
  - mode constants MODO_ALL=0, MODO_ONE=1
- One sub-module, ctrl_idx_counter: parametrised nested hold/const/fun counter with clear, advance, and last-term/last-const flags.
- The FSM and output registers stay in control_mux_seq.

Test Plan (defaults N_CONST=5, N_FUN=3, HOLD_CYCLES=1 unless noted):
- Reset, then a bandera pulse with modo=0 → CLEAR at cycle 1. During RUN, sel_const cycles 0..4 for each of sel_fun 0,1,2. acum_en=1 cycles 2..16. fun_done at cycles 7, 12, 17. done=1 at cycle 17 only.
- modo=1, fun_in=2 → sel_fun=2 throughout, 5 terms, sel_acum pattern 0,1,1,1,1. done at cycle 7.
- HOLD_CYCLES=3, modo=1, fun_in=0 → each sel_const value held 3 cycles. acum_en high on every third cycle only. done at cycle 17.
- bandera asserted again mid-RUN and held high → no restart until IDLE. A second sequence's CLEAR follows 1 IDLE cycle after done.
- rst pulsed during RUN (term c=3, f=1) → all outputs 0 immediately (async), no done/fun_done, IDLE afterwards. A fresh start still works.
- modo=1, fun_in=3 (out of range) → sel_fun saturates to 2. Normal 5-term run completes.
